// File: rtl/counter_share_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_share_ctrl: round-robin sharing of one up-counter between two
// requesters, each timed for LEN+1 cycles. Revision 1.0
// ----------------------------------------------------------------------------
module counter_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [1:0]       REQ,
  input  logic [WIDTH-1:0] LEN0,
  input  logic [WIDTH-1:0] LEN1,
  output logic [1:0]       GNT,
  output logic             BUSY,
  output logic [1:0]       DONE,
  output logic [WIDTH-1:0] Q
);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_COUNT = 2'd1;
  localparam logic [1:0] C_FIN   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic             w_win;
  logic             w_gidx;

  assign w_gidx = gnt_q[1];
  // On a tie the requester not served last wins; otherwise the lone requester.
  assign w_win  = (REQ == 2'b11) ? ~last_q : REQ[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    busy_d  = busy_q;
    last_d  = last_q;
    case (state_q)
      C_IDLE: begin
        if (REQ != 2'b00) begin
          gnt_d   = w_win ? 2'b10 : 2'b01;
          len_d   = w_win ? LEN1 : LEN0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = C_COUNT;
        end
      end
      C_COUNT: begin
        if (!REQ[w_gidx]) begin
          state_d = C_IDLE;
          gnt_d   = 2'b00;
          cnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = w_gidx;
        end else if (cnt_q == len_q) begin
          state_d = C_FIN;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      C_FIN: begin
        state_d = C_IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
        busy_d  = 1'b0;
        last_d  = w_gidx;
      end
      default: begin
        state_d = C_IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      state_q <= C_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign GNT  = gnt_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Q    = cnt_q;

endmodule
`default_nettype wire

// File: doc/counter_share_ctrl.md
Name: counter_share_ctrl

Overview:
Sequences and shares one WIDTH-bit up-counter between two requesters that each need a timed interval of LEN+1 clock cycles. The block contains a round-robin arbiter, a 3-state controller and the shared counter register. It grants the counter to one requester at a time, counts 0..LEN, pulses that requester's DONE, then frees the counter for the next request.

Parameters:
WIDTH, 4, counter and length width in bits

Ports:
C  input  1  clock; all state changes on posedge C
CLR  input  1  synchronous active-high reset; sampled on posedge C; overrides all other inputs
REQ  input  2  level request; bit i = requester i; held high until DONE[i] or until it withdraws
LEN0  input  WIDTH  terminal count for requester 0; sampled only in the grant cycle
LEN1  input  WIDTH  terminal count for requester 1; sampled only in the grant cycle
GNT  output  2  registered one-hot grant; 00 when idle
BUSY  output  1  registered; 1 whenever state is not IDLE
DONE  output  2  registered one-cycle pulse to the granted requester on completion
Q  output  WIDTH  shared counter value; valid while GNT is non-zero

Behaviour:
- Reset (CLR=1 at an edge):
  - state=IDLE, Q=0, GNT=00, DONE=00, BUSY=0.
  - Internal LAST=1, so requester 0 wins the first tie.
  - A reset during COUNT or DONE aborts immediately, with no DONE pulse.
- States: IDLE, COUNT, FIN. All outputs are registered.
- IDLE:
  - REQ=00: stay in IDLE.
  - Exactly one REQ bit set: that requester wins.
  - Both bits set: the requester other than LAST wins.
  - On the winning edge: GNT=onehot(winner), Q=0, internal L=LEN of winner, BUSY=1, go to COUNT.
- COUNT:
  - If REQ[g]=0 (withdrawn): abort. Next state IDLE, GNT=00, Q=0, BUSY=0, LAST=g, no DONE.
  - Else if Q==L: go to FIN, DONE[g]=1, Q holds.
  - Else: Q=Q+1.
- FIN:
  - Lasts exactly one cycle.
  - Next edge: IDLE, GNT=00, DONE=00, Q=0, BUSY=0, LAST=g.
  - REQ is ignored in FIN.
- Timing: for a request sampled at edge k with length L:
  - GNT is high from edge k to edge k+L+2 (L+1 COUNT cycles plus 1 FIN cycle).
  - DONE is high for the single cycle after edge k+L+1.
  - At least one IDLE cycle separates consecutive grants.
- Length rules:
  - L=0: one COUNT cycle with Q=0, then FIN.
  - L=2^WIDTH-1: Q reaches all-ones, then FIN. Q never wraps.
- L is latched at grant. LEN changes during COUNT have no effect.
- A requester that keeps REQ high after DONE is re-arbitrated in IDLE. It loses to a pending other requester, because LAST now points at it.
- GNT is always one-hot or zero. DONE is only ever set on the currently granted bit.

Test Plan:
- Reset: CLR=1 for 2 cycles with REQ=11 -> GNT=00, BUSY=0, DONE=00, Q=0 throughout. The first edge after CLR falls grants requester 0.
- Single request: REQ=01, LEN0=3 -> GNT=01 for 5 cycles, Q sequence 0,1,2,3,3, DONE[0] high only in the 5th cycle, then GNT=00 and BUSY=0.
- Tie and round-robin: REQ=11 held, LEN0=2, LEN1=1, each requester drops its bit on its DONE -> grant order 0 then 1, one IDLE cycle between grants, DONE pulses 01 then 10.
- Zero and maximum length: LEN0=0 -> GNT high for 2 cycles, Q=0. LEN1=15 -> Q counts 0..15, GNT high for 17 cycles, no wrap to 0 before FIN.
- Abort and mid-operation reset:
  - REQ0 dropped when Q=2 (LEN0=9) -> next cycle IDLE, GNT=00, no DONE.
  - Separately, CLR=1 when Q=5 -> next cycle all outputs at reset values, no DONE.
- LEN stability: LEN0 changed from 4 to 1 during COUNT -> count still runs to 4.
